// File: rtl/riscv_commit_stage.sv
// riscv_commit_stage
//   Final pipeline stage. Write-back results are queued in a small skid FIFO. The FIFO
//   drains one entry per cycle into the 32 x XLEN integer register file. The single
//   RF write port is shared with a debug port, and a debug write wins over the drain.
//   Each read port returns the youngest pending FIFO entry for its register when one
//   exists, otherwise the RF value. x0 always reads as zero.
//
//   Handshake: a result is accepted at a rising edge when wb_valid && wb_ready.
//   wb_ready is a flop (= FIFO not full next cycle), so nothing combinational feeds
//   it from the inputs. No push happens while full, even if a pop happens in the
//   same cycle. The producer may hold wb_valid high while wb_ready is low.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   wb_valid/wb_ready/wb_data/wb_rd_addr   write-back result input
//   dbg_wr_en/dbg_wr_addr/dbg_wr_data      debug RF write (stalls the drain)
//   rs1_addr/rs1_data, rs2_addr/rs2_data   combinational read ports
//   retire_count                      number of entries drained since reset (wraps)
//   commit_valid/commit_rd_addr/commit_data  registered trace of each drained entry
//                                     (present only with RISCV_COMMIT_TRACE_EN defined)
//
// Configuration macro: RISCV_COMMIT_TRACE_EN
module riscv_commit_stage #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [XLEN-1:0]  wb_data,
  input  logic [4:0]       wb_rd_addr,
  input  logic             dbg_wr_en,
  input  logic [4:0]       dbg_wr_addr,
  input  logic [XLEN-1:0]  dbg_wr_data,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [CNT_W-1:0] retire_count
`ifdef RISCV_COMMIT_TRACE_EN
  ,
  output logic             commit_valid,
  output logic [4:0]       commit_rd_addr,
  output logic [XLEN-1:0]  commit_data
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // FIFO storage and RF contents are never reset; only the pointers and level are.
  logic [XLEN-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [4:0]       fifo_rd_q   [FIFO_DEPTH];
  logic [XLEN-1:0]  rf_q        [32];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             wb_ready_q, wb_ready_d;
  logic [CNT_W-1:0] retire_count_q, retire_count_d;

  logic             push;
  logic             pop;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [XLEN-1:0]  rf_wdata;

  always_comb begin
    push = wb_valid && wb_ready_q;
    // Reset discards pending entries, so nothing drains while rst is high.
    pop  = !rst && (level_q != '0) && !dbg_wr_en;

    head_d         = head_q + PTR_W'(pop);
    tail_d         = tail_q + PTR_W'(push);
    level_d        = level_q + LVL_W'(push) - LVL_W'(pop);
    wb_ready_d     = (level_d != LVL_W'(FIFO_DEPTH));
    retire_count_d = retire_count_q + CNT_W'(pop);

    // Debug owns the write port when it asks for it, and the drain is stalled.
    if (dbg_wr_en) begin
      rf_we    = (dbg_wr_addr != 5'd0);
      rf_waddr = dbg_wr_addr;
      rf_wdata = dbg_wr_data;
    end else begin
      rf_we    = pop && (fifo_rd_q[head_q] != 5'd0);
      rf_waddr = fifo_rd_q[head_q];
      rf_wdata = fifo_data_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      level_q        <= '0;
      wb_ready_q     <= 1'b0;
      retire_count_q <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      level_q        <= level_d;
      wb_ready_q     <= wb_ready_d;
      retire_count_q <= retire_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_data_q[tail_q] <= wb_data;
      fifo_rd_q[tail_q]   <= wb_rd_addr;
    end
    if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Scan the FIFO from oldest to youngest. The last match is the youngest and wins.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
    logic [XLEN-1:0]  r;
    logic [PTR_W-1:0] idx;
    r = rf_q[addr];
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((LVL_W'(i) < level_q) && (fifo_rd_q[idx] == addr)) begin
        r = fifo_data_q[idx];
      end
    end
    if (addr == 5'd0) begin
      r = '0;
    end
    return r;
  endfunction

  always_comb rs1_data = read_port(rs1_addr);
  always_comb rs2_data = read_port(rs2_addr);

  assign wb_ready     = wb_ready_q;
  assign retire_count = retire_count_q;

`ifdef RISCV_COMMIT_TRACE_EN
  logic            commit_valid_q, commit_valid_d;
  logic [4:0]      commit_rd_q, commit_rd_d;
  logic [XLEN-1:0] commit_data_q, commit_data_d;

  always_comb begin
    commit_valid_d = pop;
    commit_rd_d    = pop ? fifo_rd_q[head_q]   : commit_rd_q;
    commit_data_d  = pop ? fifo_data_q[head_q] : commit_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_data_q  <= '0;
    end else begin
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_data_q  <= commit_data_d;
    end
  end

  assign commit_valid   = commit_valid_q;
  assign commit_rd_addr = commit_rd_q;
  assign commit_data    = commit_data_q;
`endif

endmodule

// File: tb/tb_riscv_commit_stage.sv
// Directed bench for riscv_commit_stage. The main instance uses the default parameters.
// A second instance with a 3-bit retire counter sees the same inputs, so that counter
// wrap can be observed without a long run. Each table row applies inputs, checks the
// outputs before the next edge, then clocks once.
module tb_riscv_commit_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd_addr;
  logic        dbg_wr_en;
  logic [4:0]  dbg_wr_addr;
  logic [31:0] dbg_wr_data;
  logic [4:0]  rs1_addr, rs2_addr;

  logic        wb_ready, wb_ready_s;
  logic [31:0] rs1_data, rs2_data, rs1_data_s, rs2_data_s;
  logic [63:0] retire_count;
  logic [2:0]  retire_count_s;
`ifdef RISCV_COMMIT_TRACE_EN
  logic        commit_valid, commit_valid_s;
  logic [4:0]  commit_rd_addr, commit_rd_addr_s;
  logic [31:0] commit_data, commit_data_s;
`endif

  riscv_commit_stage u_dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd_addr(wb_rd_addr), .dbg_wr_en(dbg_wr_en), .dbg_wr_addr(dbg_wr_addr),
    .dbg_wr_data(dbg_wr_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .retire_count(retire_count)
`ifdef RISCV_COMMIT_TRACE_EN
    , .commit_valid(commit_valid), .commit_rd_addr(commit_rd_addr), .commit_data(commit_data)
`endif
  );

  riscv_commit_stage #(.CNT_W(3)) u_dut_small (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready_s), .wb_data(wb_data),
    .wb_rd_addr(wb_rd_addr), .dbg_wr_en(dbg_wr_en), .dbg_wr_addr(dbg_wr_addr),
    .dbg_wr_data(dbg_wr_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data_s), .rs2_data(rs2_data_s), .retire_count(retire_count_s)
`ifdef RISCV_COMMIT_TRACE_EN
    , .commit_valid(commit_valid_s), .commit_rd_addr(commit_rd_addr_s),
    .commit_data(commit_data_s)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        dbg;
    logic [4:0]  da;
    logic [31:0] dd;
    logic        wbv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_ready;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic [63:0] e_cnt;
    logic        e_cv;
    logic [4:0]  e_crd;
    logic [31:0] e_cd;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic dbg, input logic [4:0] da, input logic [31:0] dd,
    input logic wbv, input logic [4:0] wrd, input logic [31:0] wd,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic e_ready, input logic [31:0] e_rs1, input logic [31:0] e_rs2,
    input logic [63:0] e_cnt, input logic e_cv, input logic [4:0] e_crd,
    input logic [31:0] e_cd);
    vec_t v;
    v.dbg = dbg; v.da = da; v.dd = dd; v.wbv = wbv; v.wrd = wrd; v.wd = wd;
    v.r1 = r1; v.r2 = r2; v.e_ready = e_ready; v.e_rs1 = e_rs1; v.e_rs2 = e_rs2;
    v.e_cnt = e_cnt; v.e_cv = e_cv; v.e_crd = e_crd; v.e_cd = e_cd;
    return v;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    wb_valid = 1'b0; wb_rd_addr = '0; wb_data = '0;
    dbg_wr_en = 1'b0; dbg_wr_addr = '0; dbg_wr_data = '0;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  initial begin
    // pop at edges of rows 1,4,10,11,12,17,18
    vecs[0]  = mk(0,0,0,        1,5,32'hDEADBEEF, 5,0, 1,32'h55,0,                  0, 0,0,0);
    vecs[1]  = mk(0,0,0,        0,0,0,            5,5, 1,32'hDEADBEEF,32'hDEADBEEF, 0, 0,0,0);
    vecs[2]  = mk(0,0,0,        0,0,0,            5,0, 1,32'hDEADBEEF,0,            1, 1,5,32'hDEADBEEF);
    vecs[3]  = mk(0,0,0,        1,0,32'h1234,     0,0, 1,0,0,                       1, 0,0,0);
    vecs[4]  = mk(0,0,0,        0,0,0,            0,0, 1,0,0,                       1, 0,0,0);
    vecs[5]  = mk(0,0,0,        0,0,0,            0,0, 1,0,0,                       2, 1,0,32'h1234);
    vecs[6]  = mk(1,9,32'h901,  1,1,32'h11,       5,0, 1,32'hDEADBEEF,0,            2, 0,0,0);
    vecs[7]  = mk(1,9,32'h902,  1,2,32'h22,       1,9, 1,32'h11,32'h901,            2, 0,0,0);
    vecs[8]  = mk(1,9,32'h903,  1,3,32'h33,       2,1, 0,32'h22,32'h11,             2, 0,0,0);
    vecs[9]  = mk(1,9,32'h904,  1,3,32'h33,       9,2, 0,32'h903,32'h22,            2, 0,0,0);
    vecs[10] = mk(0,0,0,        1,3,32'h33,       9,1, 0,32'h904,32'h11,            2, 0,0,0);
    vecs[11] = mk(0,0,0,        1,3,32'h33,       1,2, 1,32'h11,32'h22,             3, 1,1,32'h11);
    vecs[12] = mk(0,0,0,        0,0,0,            3,2, 1,32'h33,32'h22,             4, 1,2,32'h22);
    vecs[13] = mk(0,0,0,        0,0,0,            3,9, 1,32'h33,32'h904,            5, 1,3,32'h33);
    vecs[14] = mk(1,9,32'hA,    1,7,32'h1,        3,0, 1,32'h33,0,                  5, 0,0,0);
    vecs[15] = mk(1,9,32'hB,    1,7,32'h2,        9,7, 1,32'hA,32'h1,               5, 0,0,0);
    vecs[16] = mk(1,9,32'hC,    0,0,0,            7,7, 0,32'h2,32'h2,               5, 0,0,0);
    vecs[17] = mk(0,0,0,        0,0,0,            9,7, 0,32'hC,32'h2,               5, 0,0,0);
    vecs[18] = mk(0,0,0,        0,0,0,            0,7, 1,0,32'h2,                   6, 1,7,32'h1);
    vecs[19] = mk(0,0,0,        0,0,0,            7,7, 1,32'h2,32'h2,               7, 1,7,32'h2);

    // Reset, preload x5 by debug, then reset for 3 cycles.
    drive_idle();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    dbg_wr_en = 1'b1; dbg_wr_addr = 5'd5; dbg_wr_data = 32'h55;
    cyc();
    drive_idle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_ready_low", 64'(wb_ready), 64'd0);
    end
    rst = 1'b0;
    cyc();
    chk("post_rst_ready", 64'(wb_ready), 64'd1);
    chk("post_rst_count", retire_count, 64'd0);
    rs1_addr = 5'd5;
    #1;
    chk("post_rst_x5", 64'(rs1_data), 64'h55);
`ifdef RISCV_COMMIT_TRACE_EN
    chk("post_rst_cv", 64'(commit_valid), 64'd0);
`endif

    // Table of vectors.
    for (int i = 0; i < NV; i++) begin
      dbg_wr_en = vecs[i].dbg; dbg_wr_addr = vecs[i].da; dbg_wr_data = vecs[i].dd;
      wb_valid = vecs[i].wbv; wb_rd_addr = vecs[i].wrd; wb_data = vecs[i].wd;
      rs1_addr = vecs[i].r1; rs2_addr = vecs[i].r2;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(wb_ready), 64'(vecs[i].e_ready));
      chk($sformatf("v%0d_rs1", i), 64'(rs1_data), 64'(vecs[i].e_rs1));
      chk($sformatf("v%0d_rs2", i), 64'(rs2_data), 64'(vecs[i].e_rs2));
      chk($sformatf("v%0d_count", i), retire_count, vecs[i].e_cnt);
`ifdef RISCV_COMMIT_TRACE_EN
      chk($sformatf("v%0d_cv", i), 64'(commit_valid), 64'(vecs[i].e_cv));
      if (vecs[i].e_cv) begin
        chk($sformatf("v%0d_crd", i), 64'(commit_rd_addr), 64'(vecs[i].e_crd));
        chk($sformatf("v%0d_cdata", i), 64'(commit_data), 64'(vecs[i].e_cd));
      end
`endif
      cyc();
    end

    // Eighth drain: the 3-bit counter wraps 7 -> 0 while the wide one reaches 8.
    drive_idle();
    wb_valid = 1'b1; wb_rd_addr = 5'd10; wb_data = 32'hAA;
    cyc();
    drive_idle();
    cyc();
    rs1_addr = 5'd10;
    #1;
    chk("wrap_small_count", 64'(retire_count_s), 64'd0);
    chk("wrap_big_count", retire_count, 64'd8);
    chk("x10_written", 64'(rs1_data), 64'hAA);

    // Two pending entries under a debug stall, then reset discards them.
    dbg_wr_en = 1'b1; dbg_wr_addr = 5'd9; dbg_wr_data = 32'hD;
    wb_valid = 1'b1; wb_rd_addr = 5'd5; wb_data = 32'h111;
    cyc();
    wb_rd_addr = 5'd10; wb_data = 32'h222;
    cyc();
    rs1_addr = 5'd5; rs2_addr = 5'd10;
    #1;
    chk("pend_fwd_x5", 64'(rs1_data), 64'h111);
    chk("pend_fwd_x10", 64'(rs2_data), 64'h222);
    chk("pend_full", 64'(wb_ready), 64'd0);
    drive_idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    rs1_addr = 5'd5; rs2_addr = 5'd10;
    #1;
    chk("rst6_ready", 64'(wb_ready), 64'd1);
    chk("rst6_count", retire_count, 64'd0);
    chk("rst6_x5", 64'(rs1_data), 64'hDEADBEEF);
    chk("rst6_x10", 64'(rs2_data), 64'hAA);
    repeat (3) cyc();
    rs2_addr = 5'd9;
    #1;
    chk("rst6_later_x5", 64'(rs1_data), 64'hDEADBEEF);
    chk("rst6_later_x9", 64'(rs2_data), 64'hD);
    chk("rst6_later_count", retire_count, 64'd0);
    chk("rst6_small_count", 64'(retire_count_s), 64'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
